toggle_activity_monitor: RTL and testbench

Counts signal toggles on a bus of monitored standard-cell nets over fixed sampling windows. Streams one activity record per net to the thermal/power model over a valid/ready interface. It is the producer end of the activity path: the simulator consumes per-net activity, and this block generates it from live nets. Counting continues while the previous window is being drained, using a double-buffered snapshot.

---
 rtl/activity_monitor_pkg.sv | 14 +
 rtl/toggle_counter.sv | 24 ++
 rtl/toggle_activity_monitor.sv | 100 ++++++++++
 tb/tb_toggle_activity_monitor.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/activity_monitor_pkg.sv
// activity_monitor_pkg: shared types and width helpers for the toggle activity monitor.
package activity_monitor_pkg;

    typedef enum logic {IDLE, DUMP} dump_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rec_width(input int n, input int c);
        return idx_width(n) + c;
    endfunction

endpackage

// File: rtl/toggle_counter.sv
// toggle_counter: saturating per-net toggle counter; clr wins over inc.
module toggle_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt_inc
);

    logic [W-1:0] cnt;

    // cnt_inc already includes this cycle's toggle so a window-end snapshot sees it
    assign cnt_inc = (inc && cnt != '1) ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else
            cnt <= cnt_inc;
    end

endmodule

// File: rtl/toggle_activity_monitor.sv
// toggle_activity_monitor: windowed per-net toggle counting with a double-buffered
// snapshot streamed out as {index, count} records over valid/ready.
module toggle_activity_monitor
    import activity_monitor_pkg::*;
#(
    parameter int NUM_NETS  = 8,
    parameter int CNT_WIDTH = 16,
    parameter int WINDOW    = 1024,
    localparam int IDX_W    = idx_width(NUM_NETS),
    localparam int REC_W    = rec_width(NUM_NETS, CNT_WIDTH)
) (
    input  logic                CK,
    input  logic                RST,
    input  logic                EN,
    input  logic [NUM_NETS-1:0] NETS,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [REC_W-1:0]    OUT_DATA,
    output logic                OUT_LAST,
    output logic                OVERRUN
);

    localparam int TMR_W = $clog2(WINDOW);

    logic [NUM_NETS-1:0]  prev;
    logic [NUM_NETS-1:0]  tog;
    logic [TMR_W-1:0]     timer;
    logic [CNT_WIDTH-1:0] live_inc [NUM_NETS];
    logic [CNT_WIDTH-1:0] bank [NUM_NETS];
    dump_state_t          state;
    dump_state_t          state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic                 win_end;
    logic                 hs;
    logic                 last;
    logic                 bank_free;
    logic                 take;
    logic                 overrun;

    assign tog       = NETS ^ prev;
    assign win_end   = EN && timer == TMR_W'(WINDOW - 1);
    assign hs        = OUT_VALID && OUT_READY;
    assign last      = idx == IDX_W'(NUM_NETS - 1);
    // the bank frees up on the very edge its final record is accepted
    assign bank_free = state == IDLE || (hs && last);
    assign take      = win_end && bank_free;

    for (genvar i = 0; i < NUM_NETS; i++) begin : g_cnt
        toggle_counter #(.W(CNT_WIDTH)) u_cnt (
            .clk    (CK),
            .rst    (RST),
            .inc    (EN && tog[i]),
            .clr    (win_end),
            .cnt_inc(live_inc[i])
        );
    end

    always_ff @(posedge CK) begin
        prev <= NETS;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            timer   <= '0;
            state   <= IDLE;
            idx     <= '0;
            overrun <= 1'b0;
            bank    <= '{default: '0};
        end else begin
            if (EN)
                timer <= win_end ? '0 : timer + 1'b1;
            if (take)
                bank <= live_inc;
            if (win_end && !bank_free)
                overrun <= 1'b1;
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // a snapshot landing on the final handshake restarts the dump without a gap
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (state == IDLE) begin
            state_nxt = take ? DUMP : IDLE;
            idx_nxt   = '0;
        end else if (hs) begin
            state_nxt = (last && !take) ? IDLE : DUMP;
            idx_nxt   = last ? '0 : idx + 1'b1;
        end
    end

    assign OUT_VALID = state == DUMP;
    assign OUT_LAST  = OUT_VALID && last;
    assign OUT_DATA  = OUT_VALID ? {idx, bank[idx]} : '0;
    assign OVERRUN   = overrun;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// tb_toggle_activity_monitor: directed table and sequence checks, NUM_NETS=4, CNT_WIDTH=3, WINDOW=8.
module tb_toggle_activity_monitor;

    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic [3:0] NETS = 4'h0;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b1;
    logic [4:0] OUT_DATA;
    logic       OUT_LAST;
    logic       OVERRUN;

    int checks = 0;
    int errors = 0;

    toggle_activity_monitor #(
        .NUM_NETS (4),
        .CNT_WIDTH(3),
        .WINDOW   (8)
    ) dut (
        .CK       (CK),
        .RST      (RST),
        .EN       (EN),
        .NETS     (NETS),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_DATA (OUT_DATA),
        .OUT_LAST (OUT_LAST),
        .OVERRUN  (OVERRUN)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic [3:0] nets;
        logic       ev;
        logic [4:0] ed;
        logic       el;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] n, input logic e, input logic r, input logic rs,
                        input logic ev, input logic [4:0] ed, input logic el, input logic eo,
                        input string nm);
        NETS = n;
        EN = e;
        OUT_READY = r;
        RST = rs;
        @(posedge CK);
        #1;
        check({nm, " valid"}, int'(OUT_VALID), int'(ev));
        if (ev) begin
            check({nm, " data"}, int'(OUT_DATA), int'(ed));
            check({nm, " last"}, int'(OUT_LAST), int'(el));
        end
        check({nm, " overrun"}, int'(OVERRUN), int'(eo));
    endtask

    logic [3:0] seq4 [4];
    logic [3:0] seq5 [5];

    initial begin
        // window 1: net0 x4, net2 x1, net3 x3; window 2: net0 x7, net1 x8 (saturates), net3 x2
        tbl[0]  = '{4'h9, 1'b0, 5'd0,  1'b0};
        tbl[1]  = '{4'h1, 1'b0, 5'd0,  1'b0};
        tbl[2]  = '{4'h4, 1'b0, 5'd0,  1'b0};
        tbl[3]  = '{4'h4, 1'b0, 5'd0,  1'b0};
        tbl[4]  = '{4'hD, 1'b0, 5'd0,  1'b0};
        tbl[5]  = '{4'hD, 1'b0, 5'd0,  1'b0};
        tbl[6]  = '{4'hC, 1'b0, 5'd0,  1'b0};
        tbl[7]  = '{4'hC, 1'b1, 5'd4,  1'b0};
        tbl[8]  = '{4'h7, 1'b1, 5'd8,  1'b0};
        tbl[9]  = '{4'hC, 1'b1, 5'd17, 1'b0};
        tbl[10] = '{4'hF, 1'b1, 5'd27, 1'b1};
        tbl[11] = '{4'hC, 1'b0, 5'd0,  1'b0};
        tbl[12] = '{4'hF, 1'b0, 5'd0,  1'b0};
        tbl[13] = '{4'hC, 1'b0, 5'd0,  1'b0};
        tbl[14] = '{4'hF, 1'b0, 5'd0,  1'b0};
        tbl[15] = '{4'hD, 1'b1, 5'd7,  1'b0};
        tbl[16] = '{4'hD, 1'b1, 5'd15, 1'b0};
        tbl[17] = '{4'hD, 1'b1, 5'd16, 1'b0};
        tbl[18] = '{4'hD, 1'b1, 5'd26, 1'b1};
        tbl[19] = '{4'hD, 1'b0, 5'd0,  1'b0};

        // reset held three cycles with nets toggling; final reset edge leaves prev = 0
        seq4 = '{4'hA, 4'h5, 4'h0, 4'h0};
        for (int i = 0; i < 3; i++) begin
            NETS = seq4[i];
            EN = 1'b1;
            RST = 1'b1;
            @(posedge CK);
            #1;
            check("rst valid", int'(OUT_VALID), 0);
            check("rst data", int'(OUT_DATA), 0);
            check("rst last", int'(OUT_LAST), 0);
            check("rst overrun", int'(OVERRUN), 0);
        end

        for (int i = 0; i < 20; i++)
            step(tbl[i].nets, 1'b1, 1'b1, 1'b0, tbl[i].ev, tbl[i].ed, tbl[i].el, 1'b0, "tbl");

        // backpressure: window 3 dump stalls 12 cycles, window 4 snapshot is dropped
        seq4 = '{4'hC, 4'hD, 4'hC, 4'hD};
        for (int i = 0; i < 4; i++)
            step(seq4[i], 1'b1, 1'b0, 1'b0, i == 3, 5'd4, 1'b0, 1'b0, "bp_w3");
        for (int k = 25; k <= 36; k++)
            step(k == 25 ? 4'h9 : (k == 33 || k == 35) ? 4'h5 : k == 36 ? 4'h7 : 4'hD,
                 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, k >= 32, "bp_hold");
        step(4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b1, "bp_drain1");
        step(4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd16, 1'b0, 1'b1, "bp_drain2");
        step(4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd24, 1'b1, 1'b1, "bp_drain3");
        step(4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b1, "w5_rec0");
        step(4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9,  1'b0, 1'b1, "w5_rec1");
        step(4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd16, 1'b0, 1'b1, "w5_rec2");
        step(4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd27, 1'b1, 1'b1, "w5_rec3");
        step(4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, "w5_done");

        // EN low for 5 cycles mid-window: toggles ignored, window end slips 5 cycles
        seq5 = '{4'h6, 4'h7, 4'h6, 4'h7, 4'h6};
        for (int i = 0; i < 5; i++)
            step(seq5[i], 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, "en_off");
        step(4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, "en_on");
        step(4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, "en_on");
        step(4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, "en_on");
        step(4'h6, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, "en_w6_rec0");
        step(4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b1, "en_w6_rec1");
        step(4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 5'd16, 1'b0, 1'b1, "en_w6_rec2");
        step(4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 5'd24, 1'b1, 1'b1, "en_w6_rec3");
        step(4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, "en_w6_done");

        // window 7 (net2 x1), reset after the second record is accepted
        for (int i = 0; i < 6; i++)
            step(4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, "w7_count");
        step(4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b1, "w7_rec0");
        step(4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b1, "w7_rec1");
        step(4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd17, 1'b0, 1'b1, "w7_rec2");
        step(4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, "rst_mid");
        for (int k = 68; k <= 74; k++)
            step(k < 70 ? 4'h3 : 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "post_rst");
        step(4'h1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, "post_rec0");
        step(4'h1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9,  1'b0, 1'b0, "post_rec1");
        step(4'h1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd16, 1'b0, 1'b0, "post_rec2");
        step(4'h1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd24, 1'b1, 1'b0, "post_rec3");
        step(4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, "post_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
